// File: rtl/rotation_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rotation_decoder
// Description : Receive-side decoder for a rotator word stream. Compares each
//               sampled word against the previously sampled word (the
//               reference) and reports whether the stream moved one bit
//               left, one bit right, held, was ambiguous or broke. It also
//               tracks a modulo-WIDTH net position, saturating step/error
//               counters and a lock indication.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   data_in     in   [WIDTH-1:0] observed rotator output word
//   data_valid  in   data_in is sampled this cycle
//   clear       in   synchronous clear of position and counters
//   dir_left    out  pulse: sample was reference rotated left by 1
//   dir_right   out  pulse: sample was reference rotated right by 1
//   hold        out  pulse: sample equalled the reference
//   ambiguous   out  pulse: sample matched both rotations, not equality
//   mismatch    out  pulse: sample matched no rotation
//   position    out  [log2(WIDTH)-1:0] net rotation, modulo WIDTH
//   step_count  out  [CNT_W-1:0] left+right steps, saturating
//   err_count   out  [CNT_W-1:0] mismatches, saturating
//   locked      out  decoder is tracking cleanly
//   out_valid   out  strobe: classification outputs updated this cycle
// ============================================================================
module rotation_decoder #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_valid,
    input  logic                     clear,
    output logic                     dir_left,
    output logic                     dir_right,
    output logic                     hold,
    output logic                     ambiguous,
    output logic                     mismatch,
    output logic [$clog2(WIDTH)-1:0] position,
    output logic [CNT_W-1:0]         step_count,
    output logic [CNT_W-1:0]         err_count,
    output logic                     locked,
    output logic                     out_valid
);

    localparam int POS_W = $clog2(WIDTH);
    // Run counter only has to reach LOCK_N while in SYNC.
    localparam int RUN_W = $clog2(LOCK_N + 1);

    localparam logic [RUN_W-1:0] c_lock_n = RUN_W'(LOCK_N);

    // State encoding
    localparam logic [1:0] c_empty  = 2'd0;
    localparam logic [1:0] c_sync   = 2'd1;
    localparam logic [1:0] c_locked = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ref;
    logic [RUN_W-1:0] r_run;
    logic             r_dir_left;
    logic             r_dir_right;
    logic             r_hold;
    logic             r_ambiguous;
    logic             r_mismatch;
    logic [POS_W-1:0] r_position;
    logic [CNT_W-1:0] r_step_count;
    logic [CNT_W-1:0] r_err_count;
    logic             r_locked;
    logic             r_out_valid;

    // ------------------------------------------------------------------------
    // Classification of data_in against the reference
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic             w_eq;
    logic             w_match_l;
    logic             w_match_r;
    logic             w_is_hold;
    logic             w_is_amb;
    logic             w_is_left;
    logic             w_is_right;
    logic             w_is_mis;
    logic             w_clean;
    logic             w_classify;
    logic [RUN_W-1:0] w_run_inc;

    assign w_rotl    = {r_ref[WIDTH-2:0], r_ref[WIDTH-1]};
    assign w_rotr    = {r_ref[0], r_ref[WIDTH-1:1]};
    assign w_eq      = (data_in == r_ref);
    assign w_match_l = (data_in == w_rotl);
    assign w_match_r = (data_in == w_rotr);

    // Equality has top priority: for all-zeros/all-ones words every rotation
    // equals the reference, and that must read as hold, not ambiguous.
    assign w_is_hold  = w_eq;
    assign w_is_amb   = !w_eq && w_match_l && w_match_r;
    assign w_is_left  = !w_eq && w_match_l && !w_match_r;
    assign w_is_right = !w_eq && !w_match_l && w_match_r;
    assign w_is_mis   = !w_eq && !w_match_l && !w_match_r;
    assign w_clean    = w_is_hold || w_is_left || w_is_right;

    // The first sample after EMPTY only seeds the reference.
    assign w_classify = data_valid && (r_state != c_empty);
    assign w_run_inc  = r_run + 1'b1;

    // ------------------------------------------------------------------------
    // Next position / counter values. clear overrides any classified update.
    // ------------------------------------------------------------------------
    logic [POS_W-1:0] w_position_nxt;
    logic [CNT_W-1:0] w_step_nxt;
    logic [CNT_W-1:0] w_err_nxt;

    always_comb begin
        w_position_nxt = r_position;
        w_step_nxt     = r_step_count;
        w_err_nxt      = r_err_count;

        if (w_classify) begin
            if (w_is_left) begin
                w_position_nxt = r_position + 1'b1;
            end else if (w_is_right) begin
                w_position_nxt = r_position - 1'b1;
            end

            if ((w_is_left || w_is_right) && !(&r_step_count)) begin
                w_step_nxt = r_step_count + 1'b1;
            end

            if (w_is_mis && !(&r_err_count)) begin
                w_err_nxt = r_err_count + 1'b1;
            end
        end

        if (clear) begin
            w_position_nxt = '0;
            w_step_nxt     = '0;
            w_err_nxt      = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_empty;
            r_ref        <= '0;
            r_run        <= '0;
            r_dir_left   <= 1'b0;
            r_dir_right  <= 1'b0;
            r_hold       <= 1'b0;
            r_ambiguous  <= 1'b0;
            r_mismatch   <= 1'b0;
            r_position   <= '0;
            r_step_count <= '0;
            r_err_count  <= '0;
            r_locked     <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            // Flags are single-cycle pulses qualified by out_valid.
            r_out_valid  <= w_classify;
            r_dir_left   <= w_classify && w_is_left;
            r_dir_right  <= w_classify && w_is_right;
            r_hold       <= w_classify && w_is_hold;
            r_ambiguous  <= w_classify && w_is_amb;
            r_mismatch   <= w_classify && w_is_mis;

            r_position   <= w_position_nxt;
            r_step_count <= w_step_nxt;
            r_err_count  <= w_err_nxt;

            // The reference always follows the latest sample, so a mismatch
            // resynchronises on the offending word.
            if (data_valid) begin
                r_ref <= data_in;
            end

            case (r_state)
                c_empty: begin
                    if (data_valid) begin
                        r_state <= c_sync;
                        r_run   <= '0;
                    end
                end

                c_sync: begin
                    if (data_valid) begin
                        if (w_clean) begin
                            if (w_run_inc >= c_lock_n) begin
                                r_state  <= c_locked;
                                r_locked <= 1'b1;
                                r_run    <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                end

                c_locked: begin
                    if (data_valid && !w_clean) begin
                        r_state  <= c_sync;
                        r_locked <= 1'b0;
                        r_run    <= '0;
                    end
                end

                default: begin
                    // Unused encoding: recover through a fresh capture.
                    r_state  <= c_empty;
                    r_locked <= 1'b0;
                    r_run    <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dir_left   = r_dir_left;
    assign dir_right  = r_dir_right;
    assign hold       = r_hold;
    assign ambiguous  = r_ambiguous;
    assign mismatch   = r_mismatch;
    assign position   = r_position;
    assign step_count = r_step_count;
    assign err_count  = r_err_count;
    assign locked     = r_locked;
    assign out_valid  = r_out_valid;

endmodule
`default_nettype wire
